fixed_point_multiplier: RTL and testbench

- Sequential shift-add unsigned fixed-point multiplier; the inverse-operation partner of fixed_point_division in the arithmetic datapath, with the same operand-load/start interface and the same Q-format.
- Operands are loaded via ld_a/ld_b and multiplied one bit per clock.
- Result is truncated back to operand format, with an overflow flag.
- Status outputs busy/done let a controller sequence multiply and divide operations.

---
 rtl/fixed_point_multiplier.sv | 134 +++++++++++++
 tb/tb_fixed_point_multiplier.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier.sv
// Sequential shift-add unsigned fixed-point multiplier, one multiplier bit per clock.
// Product is truncated back to Q(W-FW).FW with an overflow flag on the discarded high bits.
module fixed_point_multiplier #(
   parameter int W  = 10,
   parameter int FW = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         ld_a,
   input  logic         ld_b,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] q,
   output logic         ov,
   output logic         busy,
   output logic         done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [2*W-1:0]  p_q, p_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    q_q, q_d;
   logic            ov_q, ov_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [W-1:0]    addend_s;
   logic [W:0]      sum_s;
   logic [2*W-1:0]  p_iter_s;

   // One shift-add step: conditional add into the upper half, then shift {carry, P} right.
   always_comb begin
      if (p_q[0]) begin
         addend_s = a_q;
      end else begin
         addend_s = {W{1'b0}};
      end
      sum_s    = {1'b0, p_q[2*W-1:W]} + {1'b0, addend_s};
      p_iter_s = {sum_s, p_q[W-1:1]};
   end

   // Next-state and datapath update; operands load only while not iterating.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ov_d    = ov_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ld_a) begin
               a_d = A;
            end else begin
               a_d = a_q;
            end
            if (ld_b) begin
               b_d = B;
            end else begin
               b_d = b_q;
            end
            if (start) begin
               state_d = ST_BUSY;
               cnt_d   = {CW{1'b0}};
               p_d     = {{W{1'b0}}, b_d};
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            p_d   = p_iter_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               q_d     = p_iter_s[W+FW-1:FW];
               ov_d    = |p_iter_s[2*W-1:W+FW];
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         p_q     <= {(2*W){1'b0}};
         cnt_q   <= {CW{1'b0}};
         q_q     <= {W{1'b0}};
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign ov   = ov_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Bench for fixed_point_multiplier: directed and randomized operations checked against
// an arithmetic reference (integer product, shifted and masked).
module tb_fixed_point_multiplier;

   localparam int W  = 10;
   localparam int FW = 6;

   logic         clk;
   logic         rst;
   logic         start;
   logic         ld_a;
   logic         ld_b;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] q;
   logic         ov;
   logic         busy;
   logic         done;

   int checks;
   int failures;

   // Reference operand registers as the controller sees them.
   int unsigned ma;
   int unsigned mb;

   fixed_point_multiplier #(.W(W), .FW(FW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ld_a  (ld_a),
      .ld_b  (ld_b),
      .A     (A),
      .B     (B),
      .q     (q),
      .ov    (ov),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_q(input int unsigned a, input int unsigned b);
      int unsigned prod;
      prod = a * b;
      return (prod >> FW) % (1 << W);
   endfunction

   function automatic logic [31:0] ref_ov(input int unsigned a, input int unsigned b);
      int unsigned prod;
      prod = a * b;
      return ((prod >> (W + FW)) != 0) ? 32'd1 : 32'd0;
   endfunction

   // Issue one operation from a negedge and follow it to the done pulse.
   // With junk=1, new operands and start are pushed in during the third busy cycle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic lda, input logic ldb, input logic junk);
      int cycles;
      logic [W-1:0] q_before;
      A = a; B = b; ld_a = lda; ld_b = ldb; start = 1'b1;
      if (lda) ma = a;
      if (ldb) mb = b;
      @(negedge clk);
      q_before = q;
      start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
      check_val("busy_after_start", {31'd0, busy}, 32'd1);
      cycles = 0;
      while (busy && cycles < W + 4) begin
         if (junk && cycles == 2) begin
            A = W'($urandom); B = W'($urandom);
            ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
         end
         if (cycles == 5) check_val("q_held_in_busy", {22'd0, q}, {22'd0, q_before});
         @(negedge clk);
         cycles++;
      end
      start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
      check_val("busy_cycles", cycles, W);
      check_val("done_pulse", {31'd0, done}, 32'd1);
      check_val("q", {22'd0, q}, ref_q(ma, mb));
      check_val("ov", {31'd0, ov}, ref_ov(ma, mb));
   endtask

   task automatic idle_after;
      logic [W-1:0] q_hold;
      q_hold = q;
      @(negedge clk);
      check_val("done_one_cycle", {31'd0, done}, 32'd0);
      check_val("idle_not_busy", {31'd0, busy}, 32'd0);
      check_val("q_hold_idle", {22'd0, q}, {22'd0, q_hold});
   endtask

   initial begin
      checks = 0; failures = 0;
      ma = 0; mb = 0;
      rst = 1'b0; start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
      A = {W{1'b0}}; B = {W{1'b0}};
      repeat (3) @(negedge clk);
      check_val("reset_q", {22'd0, q}, 32'd0);
      check_val("reset_ov", {31'd0, ov}, 32'd0);
      check_val("reset_busy", {31'd0, busy}, 32'd0);
      check_val("reset_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed vectors with explicit expected results.
      do_op(10'b0000100000, 10'b0000010000, 1'b1, 1'b1, 1'b0);
      check_val("dir_half_quarter", {22'd0, q}, 32'd8);
      idle_after();
      do_op(10'b1000000000, 10'b0010000000, 1'b1, 1'b1, 1'b0);
      check_val("dir_ovf_q", {22'd0, q}, 32'd0);
      check_val("dir_ovf_ov", {31'd0, ov}, 32'd1);
      idle_after();
      do_op(10'b0000000001, 10'b0000100000, 1'b1, 1'b1, 1'b0);
      check_val("dir_trunc_q", {22'd0, q}, 32'd0);
      idle_after();
      do_op(10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0);
      check_val("dir_max_q", {22'd0, q}, 32'd992);
      check_val("dir_max_ov", {31'd0, ov}, 32'd1);
      idle_after();

      // Inputs changed mid-iteration must be ignored.
      do_op(10'd200, 10'd77, 1'b1, 1'b1, 1'b1);
      idle_after();
      // Operands retained after the ignored loads.
      do_op(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      idle_after();

      // Asynchronous reset mid-operation.
      A = 10'd500; B = 10'd300; ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      check_val("midrst_done", {31'd0, done}, 32'd0);
      check_val("midrst_q", {22'd0, q}, 32'd0);
      check_val("midrst_ov", {31'd0, ov}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      ma = 0; mb = 0;
      @(negedge clk);
      check_val("postrst_no_done", {31'd0, done}, 32'd0);
      do_op(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
      check_val("postrst_q_zero", {22'd0, q}, 32'd0);
      idle_after();

      // Randomized operations, some chained back-to-back from the DONE cycle.
      for (int i = 0; i < 24; i++) begin
         logic lda;
         logic ldb;
         lda = ($urandom_range(3) != 0);
         ldb = ($urandom_range(3) != 0);
         do_op(W'($urandom), W'($urandom), lda, ldb, 1'($urandom_range(1)));
         if ($urandom_range(1) == 0) idle_after();
      end
      do_op(W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b0);
      do_op(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0);
      do_op(W'($urandom), W'($urandom), 1'b0, 1'b1, 1'b0);
      idle_after();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
